// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   Multiplies by shift-add and divides by restoring division, one bit
//   per cycle. It also services the MTHI/MTLO register writes.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     request, sampled only while busy=0
//   op        0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=ignored
//   a, b      operands (a is also the MTHI/MTLO source)
//   busy      iterative operation in progress
//   done      one-cycle pulse after HI/LO have been written
//   div_zero  sticky: the last DIV/DIVU had b=0; cleared by the next accepted start
//   hi, lo    architectural HI/LO registers
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO complete here in one edge
//   CALC  | WIDTH iterations of shift-add or restoring divide
//   FIXUP | sign correction, HI/LO write, done pulse
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_orig;    // raw dividend, returned in HI on divide-by-zero
    logic               is_div;
    logic               neg_lo;    // negate product / quotient
    logic               neg_hi;    // negate remainder (dividend was negative)
    logic               b_zero;

    logic               accept;
    logic               op_signed;
    logic               op_arith;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    assign busy   = (state != S_IDLE);
    assign accept = start && (state == S_IDLE);

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        a_abs     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (op_signed && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        // The restored remainder is always below the divisor, so WIDTH bits hold it.
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
        lo_fix   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                hi_fix = a_orig;
                lo_fix = '1;
            end else begin
                hi_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            b_zero   <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && op_arith) begin
                        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
                        neg_lo   <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi   <= (op == OP_DIV) && a[WIDTH-1];
                        b_zero   <= (b == '0);
                        a_orig   <= a;
                        // Multiplier bits shift out of the low half; dividend bits
                        // shift out of the top of the low half.
                        if ((op == OP_DIV) || (op == OP_DIVU)) begin
                            acc  <= {{WIDTH{1'b0}}, a_abs};
                            opnd <= b_abs;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                            opnd <= a_abs;
                        end
                        cnt      <= CW'(WIDTH);
                        div_zero <= 1'b0;
                        state    <= S_CALC;
                    end else if (accept && (op == OP_MTHI)) begin
                        hi       <= a;
                        done     <= 1'b1;
                        div_zero <= 1'b0;
                    end else if (accept && (op == OP_MTLO)) begin
                        lo       <= a;
                        done     <= 1'b1;
                        div_zero <= 1'b0;
                    end
                end
                S_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    hi       <= hi_fix;
                    lo       <= lo_fix;
                    div_zero <= is_div && b_zero;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive a request for one edge; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        a     = $urandom;
        b     = $urandom;
    endtask

    // Counts edges until done, bounded; also flags any cycle with busy and done together.
    task automatic wait_done(output int edges, output int busy_cnt, output int overlap);
        edges    = 0;
        busy_cnt = 0;
        overlap  = 0;
        while (!done && edges < 60) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (busy && done) overlap = 1;
    endtask

    initial begin
        int edges, bcnt, ovl, saw;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div_zero", div_zero, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // MULT -3 * 5
        start_op(3'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult_busy_rises", busy, 1);
        check("mult_hi_held", hi, 0);
        wait_done(edges, bcnt, ovl);
        check("mult_done", done, 1);
        check("mult_latency", edges, W + 1);
        check("mult_busy_cycles", bcnt, W + 1);
        check("mult_no_overlap", ovl, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU max*max, started in the done cycle of the previous op
        start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_accept_in_done", busy, 1);
        check("multu_done_pulse", done, 0);
        wait_done(edges, bcnt, ovl);
        check("multu_done", done, 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, bcnt, ovl);
        check("div_latency", edges, W + 1);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2: quotient -3, remainder follows the dividend (+1)
        start_op(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done(edges, bcnt, ovl);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'd1);

        // DIV signed overflow
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, bcnt, ovl);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        check("div_ovf_dz", div_zero, 0);

        // DIVU by zero
        start_op(3'd3, 32'd7, 32'd0);
        wait_done(edges, bcnt, ovl);
        check("divz_latency", edges, W + 1);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd7);
        check("divz_flag", div_zero, 1);
        @(posedge clk);
        #1;
        check("divz_flag_sticky", div_zero, 1);

        // MTHI clears div_zero, done one cycle later, no busy
        start_op(3'd4, 32'h1234, 32'd0);
        check("mthi_done", done, 1);
        check("mthi_busy", busy, 0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_dz_clear", div_zero, 0);
        check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("mthi_done_once", done, 0);
        check("mthi_busy_after", busy, 0);

        // Reserved op is ignored
        start_op(3'd6, 32'h5555, 32'h1);
        check("rsvd_no_done", done, 0);
        check("rsvd_no_busy", busy, 0);
        check("rsvd_hi_kept", hi, 32'h1234);

        // MULTU 3*4 with an ignored DIVU start while busy
        start_op(3'd1, 32'd3, 32'd4);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges, bcnt, ovl);
        check("busy_ignore_latency", edges, W + 1 - 5);
        check("busy_ignore_hi", hi, 32'd0);
        check("busy_ignore_lo", lo, 32'd12);
        @(posedge clk);
        #1;
        check("busy_ignore_no_second", busy, 0);

        // Reset mid-operation aborts
        start_op(3'd3, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dz", div_zero, 0);
        saw = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1;
        end
        check("abort_quiet", saw, 0);
        check("abort_lo_after", lo, 0);

        start_op(3'd5, 32'hAB, 32'd0);
        check("mtlo_lo", lo, 32'hAB);
        check("mtlo_done", done, 1);
        check("mtlo_hi_kept", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
